// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM bus between NUM_REQ
// requesters. Grant and bus drive are combinational; read data is routed
// back one cycle after the grant to the requester that issued the read.
// Optional feature macro: BRAM_ARBITER_LOCK_EN adds req_lock, letting the
// granted requester keep the bus for atomic read-modify-write sequences.
module bram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
`ifdef BRAM_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]               req_lock,
`endif
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_write_data,
  output logic                             mem_write_enable,
  input  logic [DATA_WIDTH-1:0]            mem_read_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   scan_idx;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic               gnt_hit;
  logic               rd_grant;
  logic               rd_pending;
  logic [NUM_REQ-1:0] rd_tag;

`ifdef BRAM_ARBITER_LOCK_EN
  logic               lock_active;
  logic [PTR_W-1:0]   lock_idx;
`endif

  // Pick the winner: a held lock first, otherwise the first requester at or after rr_ptr
  always_comb begin
    gnt_hit  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    if (rst_n) begin
`ifdef BRAM_ARBITER_LOCK_EN
      if (lock_active && req[lock_idx] && req_lock[lock_idx]) begin
        gnt_hit = 1'b1;
        gnt_idx = lock_idx;
      end
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (!gnt_hit && req[scan_idx]) begin
          gnt_hit = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
  end

  assign next_ptr = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
  assign rd_grant = gnt_hit && !req_we[gnt_idx];

  // Drive the one-hot grant and the winner's access onto the BRAM bus; idle bus is all zero
  always_comb begin
    gnt              = '0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    if (gnt_hit) begin
      gnt[gnt_idx]     = 1'b1;
      mem_address      = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_write_data   = req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      mem_write_enable = req_we[gnt_idx];
    end
  end

  // Advance the round-robin pointer past each winner and tag the read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      rd_pending <= 1'b0;
      rd_tag     <= '0;
    end else begin
      if (gnt_hit) begin
        rr_ptr <= next_ptr;
      end
      rd_pending <= rd_grant;
      rd_tag     <= rd_grant ? gnt : '0;
    end
  end

`ifdef BRAM_ARBITER_LOCK_EN
  // Remember a locking winner; the lock lapses as soon as it is not re-granted through it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_active <= 1'b0;
      lock_idx    <= '0;
    end else begin
      lock_active <= gnt_hit && req_lock[gnt_idx];
      lock_idx    <= gnt_idx;
    end
  end
`endif

  // ---- read return stage: BRAM data lands one cycle after the read grant ----
  assign rvalid = rd_pending ? rd_tag : '0;
  assign rdata  = rd_pending ? mem_read_data : '0;

endmodule
